// File: rtl/btn_event_sched.sv
// btn_event_sched: debounces N active-low buttons and serialises their press/release
// events onto one valid/ready stream through a round-robin arbiter.
module btn_event_sched #(
  parameter int N         = 4,
  parameter int CNT_W     = 16,
  parameter int DB_CYCLES = 16,
  parameter int ID_W      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    btn,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [ID_W-1:0] ev_id,
  output logic            ev_type,
  output logic [N-1:0]    pressed,
  output logic            overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] v);
    return (v == ID_LAST) ? '0 : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser, preset to the released level
  logic [N-1:0] sync_p0, sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Per-channel debounce FSM operating on the synchronised level
  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];
  logic [N-1:0]     set_press, set_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (!sync_p1[i]) begin
            state_d[i] = PRESS_CHK;
            cnt_d[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (sync_p1[i])                  state_d[i] = IDLE;
          else if (cnt_q[i] == CNT_LAST)   state_d[i] = PRESSED;
          else                             cnt_d[i]   = cnt_inc(cnt_q[i]);
        end
        PRESSED: begin
          if (sync_p1[i]) begin
            state_d[i] = REL_CHK;
            cnt_d[i]   = '0;
          end
        end
        REL_CHK: begin
          if (!sync_p1[i])                 state_d[i] = PRESSED;
          else if (cnt_q[i] == CNT_LAST)   state_d[i] = IDLE;
          else                             cnt_d[i]   = cnt_inc(cnt_q[i]);
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    pressed   = '0;
    set_press = '0;
    set_rel   = '0;
    for (int i = 0; i < N; i++) begin
      pressed[i]   = (state_q[i] == PRESSED) || (state_q[i] == REL_CHK);
      set_press[i] = (state_q[i] == PRESS_CHK) && !sync_p1[i] && (cnt_q[i] == CNT_LAST);
      set_rel[i]   = (state_q[i] == REL_CHK)   &&  sync_p1[i] && (cnt_q[i] == CNT_LAST);
    end
  end

  // Round-robin selection: lowest pending channel at or above rr_ptr, else lowest below it
  logic [N-1:0]    press_pend, rel_pend, pend_any;
  logic [N-1:0]    clr_press, clr_rel;
  logic [ID_W-1:0] rr_ptr, grant_id;
  logic            grant_vld, grant_type, load;

  assign pend_any = press_pend | rel_pend;
  assign load     = !ev_valid || ev_ready;

  always_comb begin
    grant_vld  = 1'b0;
    grant_id   = '0;
    grant_type = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!grant_vld && pend_any[j] && (ID_W'(j) >= rr_ptr)) begin
        grant_vld  = 1'b1;
        grant_id   = ID_W'(j);
        grant_type = press_pend[j];
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!grant_vld && pend_any[j] && (ID_W'(j) < rr_ptr)) begin
        grant_vld  = 1'b1;
        grant_id   = ID_W'(j);
        grant_type = press_pend[j];
      end
    end
  end

  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    for (int j = 0; j < N; j++) begin
      if (load && grant_vld && (grant_id == ID_W'(j))) begin
        clr_press[j] = grant_type;
        clr_rel[j]   = !grant_type;
      end
    end
  end

  // A new set wins over a same-cycle clear; a set onto a still-pending bit is a drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend <= '0;
      rel_pend   <= '0;
      overflow   <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~clr_press) | set_press;
      rel_pend   <= (rel_pend & ~clr_rel) | set_rel;
      if ((|(set_press & press_pend & ~clr_press)) || (|(set_rel & rel_pend & ~clr_rel)))
        overflow <= 1'b1;
    end
  end

  // Output slot: refills when empty or on a handshake, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_type  <= 1'b0;
      rr_ptr   <= '0;
    end else if (load) begin
      ev_valid <= grant_vld;
      if (grant_vld) begin
        ev_id   <= grant_id;
        ev_type <= grant_type;
        rr_ptr  <= ptr_inc(grant_id);
      end
    end
  end

endmodule
